// File: rtl/write_arb_pkg.sv
// Shared definitions for the write-path arbitration scheduler.
//   arb_state_e : scheduler FSM states (IDLE between packets, XFER while
//                 beats of the granted packet are being issued)
//   PORT_IDX_W  : width of a port index; sel_port is this wide, so at most
//                 16 ports can be scheduled
//   LEN_W       : default width of a per-port packet-length field in beats
//   wrap_idx    : folds a sum of two in-range port indices back into the
//                 range 0..modulus-1
package write_arb_pkg;

  localparam int PORT_IDX_W = 4;
  localparam int LEN_W      = 8;
  localparam int MAX_PORTS  = 1 << PORT_IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Operands are always below the modulus, so one conditional subtract is
  // enough and avoids a real divider.
  function automatic logic [PORT_IDX_W-1:0] wrap_idx(
    input logic [PORT_IDX_W:0] value,
    input int                  modulus
  );
    int v;
    v = int'(value);
    if (v >= modulus) begin
      v = v - modulus;
    end
    return PORT_IDX_W'(v);
  endfunction

endpackage

// File: rtl/write_arb_scheduler_if.sv
// Bundle of the request, grant and selecter-control signals of the write
// arbitration scheduler.
//   req        : per-port write request, held until granted
//   req_len    : packed per-port packet lengths, port i at
//                [(i+1)*len_width-1 : i*len_width]
//   ready      : SRAM write side accepts a beat this cycle
//   grant      : one-hot grant, held for the whole packet
//   sel_port   : selecter select, index of the granted port
//   sel_enable : selecter enable, high for each beat issued
//   busy       : packet in progress
//   pkt_done   : one-cycle pulse in the cycle after the last beat
// Modport master belongs to the requesters / SRAM side, modport slave to
// the scheduler itself.
interface write_arb_scheduler_if #(
  parameter int num_of_ports = 16,
  parameter int len_width    = write_arb_pkg::LEN_W
);

  logic [num_of_ports-1:0]           req;
  logic [num_of_ports*len_width-1:0] req_len;
  logic                              ready;
  logic [num_of_ports-1:0]           grant;
  logic [write_arb_pkg::PORT_IDX_W-1:0] sel_port;
  logic                              sel_enable;
  logic                              busy;
  logic                              pkt_done;

  modport master (
    output req,
    output req_len,
    output ready,
    input  grant,
    input  sel_port,
    input  sel_enable,
    input  busy,
    input  pkt_done
  );

  modport slave (
    input  req,
    input  req_len,
    input  ready,
    output grant,
    output sel_port,
    output sel_enable,
    output busy,
    output pkt_done
  );

endinterface

// File: rtl/write_arb_scheduler_picker.sv
// Combinational round-robin priority picker.
//   req       : request vector, one bit per port
//   last_port : port served most recently; it gets the lowest priority
//   winner    : index of the first requesting port after last_port,
//               wrapping modulo num_of_ports
//   valid     : at least one port is requesting
// The request vector is rotated so that port last_port+1 lands at bit 0,
// the lowest set bit is found, and the offset is rotated back.
module rr_priority_picker
  import write_arb_pkg::*;
#(
  parameter int num_of_ports = 16
) (
  input  logic [num_of_ports-1:0] req,
  input  logic [PORT_IDX_W-1:0]   last_port,
  output logic [PORT_IDX_W-1:0]   winner,
  output logic                    valid
);

  logic [PORT_IDX_W-1:0]   start;
  logic [PORT_IDX_W-1:0]   offset;
  logic [num_of_ports-1:0] rotated;

  always_comb begin
    start   = wrap_idx({1'b0, last_port} + (PORT_IDX_W + 1)'(1), num_of_ports);
    rotated = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      rotated[i] = req[wrap_idx({1'b0, start} + (PORT_IDX_W + 1)'(i), num_of_ports)];
    end

    // Scan from the top down so the lowest set bit is the one that sticks.
    offset = '0;
    valid  = 1'b0;
    for (int i = num_of_ports - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = PORT_IDX_W'(i);
        valid  = 1'b1;
      end
    end

    winner = wrap_idx({1'b0, start} + {1'b0, offset}, num_of_ports);
  end

endmodule

// File: rtl/write_arb_scheduler.sv
// Round-robin write scheduler in front of the write path's channel
// selecter. One requesting port is granted at a time and keeps the grant
// until every beat of its packet has been accepted by the SRAM side.
//   clk : system clock
//   rst : synchronous reset, active-high; aborts any packet in flight
//   bus : slave side of write_arb_scheduler_if (requests, lengths, ready
//         in; grant, sel_port, sel_enable, busy, pkt_done out)
// Requests and lengths are only looked at while idle; the selecter
// registers its output, so SRAM data trails sel_enable by one cycle.
module write_arb_scheduler
  import write_arb_pkg::*;
#(
  parameter int num_of_ports = 16,
  parameter int len_width    = LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  write_arb_scheduler_if.slave bus
);

  arb_state_e              state_q, state_d;
  logic [num_of_ports-1:0] grant_q, grant_d;
  logic [PORT_IDX_W-1:0]   sel_port_q, sel_port_d;
  logic [PORT_IDX_W-1:0]   last_port_q, last_port_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [len_width-1:0]    beat_cnt_q, beat_cnt_d;

  logic [PORT_IDX_W-1:0]   winner;
  logic                    winner_valid;
  logic [len_width-1:0]    winner_len;

  rr_priority_picker #(
    .num_of_ports (num_of_ports)
  ) u_picker (
    .req       (bus.req),
    .last_port (last_port_q),
    .winner    (winner),
    .valid     (winner_valid)
  );

  // Length field of whichever port the picker chose.
  always_comb begin
    winner_len = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      if (winner == PORT_IDX_W'(i)) begin
        winner_len = bus.req_len[i*len_width +: len_width];
      end
    end
  end

  // Next-state logic. beat_cnt holds the beats still to issue including
  // the current one, so the packet ends on the accepted beat where it is 1.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_port_d  = sel_port_q;
    last_port_d = last_port_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (winner_valid) begin
          state_d    = XFER;
          grant_d    = num_of_ports'(1) << winner;
          sel_port_d = winner;
          // A zero length would otherwise never finish; run it as one beat.
          beat_cnt_d = (winner_len == '0) ? len_width'(1) : winner_len;
        end
      end

      XFER: begin
        if (bus.ready) begin
          if (beat_cnt_q == len_width'(1)) begin
            state_d     = IDLE;
            grant_d     = '0;
            last_port_d = sel_port_q;
            pkt_done_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - len_width'(1);
          end
        end
      end
    endcase
  end

  // State register; reset leaves the last port at the top index so port 0
  // wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_port_q  <= '0;
      last_port_q <= PORT_IDX_W'(num_of_ports - 1);
      pkt_done_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_port_q  <= sel_port_d;
      last_port_q <= last_port_d;
      pkt_done_q  <= pkt_done_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // sel_enable follows ready combinationally so a beat is steered only in
  // a cycle the SRAM side actually takes it; sel_port alone never enables.
  assign bus.grant      = grant_q;
  assign bus.sel_port   = sel_port_q;
  assign bus.busy       = (state_q == XFER);
  assign bus.sel_enable = (state_q == XFER) & bus.ready;
  assign bus.pkt_done   = pkt_done_q;

endmodule
